// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU control unit.
// Contents: FSM state encodings, ALU operation codes, primary opcodes,
// R-type funct codes, PC source selects, the wait-counter width and an
// opcode legality helper. Both multicycle_control and alu_funct_dec
// import this package.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Wide enough for the largest allowed TIMEOUT (255).
  localparam int WAIT_W = 8;

  // bne/andi/ori only exist when the extended decode is enabled.
  function automatic logic op_is_legal(input logic [5:0] op, input logic ext_en);
    case (op)
      OP_R, OP_J, OP_LW, OP_SW, OP_BEQ, OP_ADDIU: return 1'b1;
      OP_BNE, OP_ANDI, OP_ORI:                    return ext_en;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// R-type funct field to ALU operation decoder.
// Ports:
//   funct   in  6  funct field of the instruction
//   alu_op  out 4  ALU operation code (ADD when funct is unrecognised)
//   illegal out 1  funct is not a supported R-type operation
module alu_funct_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU: alu_op = ALU_ADD;
      FN_SUB, FN_SUBU: alu_op = ALU_SUB;
      FN_AND:          alu_op = ALU_AND;
      FN_OR:           alu_op = ALU_OR;
      FN_SLT:          alu_op = ALU_SLT;
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with a memory wait timeout and a sticky TRAP state left only by rst.
// Parameters:
//   TIMEOUT  consecutive not-ready memory cycles that trigger a trap (1..255)
//   EXT_EN   1 enables bne/andi/ori decode, 0 treats them as illegal
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ct_inst, aluct_inst      opcode and funct from the instruction register
//   alu_zero, mem_ready      ALU zero flag, memory access complete
//   ct_pc_wen, ct_pc_src     PC write enable and source select
//   ct_ir_wen                instruction register write enable
//   ct_iord                  memory address select (0=PC, 1=ALU)
//   ct_mem_ren, ct_mem_wen   memory read / write requests
//   ct_rf_wen, ct_rf_dst     register file write enable, destination select
//   ct_data_rf               RF write data select (1=memory, 0=ALU)
//   ct_alu_src, ct_zext      ALU operand B select, immediate extension
//   ct_alu                   ALU operation
//   ct_illegal, ct_state     trap flag, current state encoding
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter bit          EXT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ct_inst,
  input  logic [5:0] aluct_inst,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       ct_pc_wen,
  output logic [1:0] ct_pc_src,
  output logic       ct_ir_wen,
  output logic       ct_iord,
  output logic       ct_mem_ren,
  output logic       ct_mem_wen,
  output logic       ct_rf_wen,
  output logic       ct_rf_dst,
  output logic       ct_data_rf,
  output logic       ct_alu_src,
  output logic       ct_zext,
  output logic [3:0] ct_alu,
  output logic       ct_illegal,
  output logic [2:0] ct_state
);

  state_e              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                timeout_hit;
  logic                is_mem_op;
  logic [3:0]          funct_alu;
  logic                funct_bad;

  alu_funct_dec u_funct_dec (
    .funct   (aluct_inst),
    .alu_op  (funct_alu),
    .illegal (funct_bad)
  );

  // wait_cnt holds the number of wait cycles already spent; the current
  // cycle is the TIMEOUT-th one when it equals TIMEOUT-1. A ready in that
  // cycle still wins over the trap.
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign is_mem_op   = (ct_inst == OP_LW) || (ct_inst == OP_SW);

  assign ct_state   = state;
  assign ct_illegal = (state == ST_TRAP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state logic; the counter only survives a cycle that stays in a
  // waiting FETCH or MEM, so any state change clears it.
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      ST_FETCH: begin
        if (mem_ready)        state_nxt = ST_DECODE;
        else if (timeout_hit) state_nxt = ST_TRAP;
        else                  wait_nxt  = wait_cnt + 1'b1;
      end
      ST_DECODE: begin
        if (ct_inst == OP_J)                   state_nxt = ST_FETCH;
        else if (!op_is_legal(ct_inst, EXT_EN)) state_nxt = ST_TRAP;
        else                                   state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (ct_inst)
          OP_R:           state_nxt = funct_bad ? ST_TRAP : ST_WB;
          OP_LW, OP_SW:   state_nxt = ST_MEM;
          OP_ADDIU:       state_nxt = ST_WB;
          OP_ANDI, OP_ORI: state_nxt = EXT_EN ? ST_WB : ST_TRAP;
          OP_BEQ:         state_nxt = ST_FETCH;
          OP_BNE:         state_nxt = EXT_EN ? ST_FETCH : ST_TRAP;
          default:        state_nxt = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (!is_mem_op)       state_nxt = ST_TRAP;
        else if (mem_ready)   state_nxt = (ct_inst == OP_LW) ? ST_WB : ST_FETCH;
        else if (timeout_hit) state_nxt = ST_TRAP;
        else                  wait_nxt  = wait_cnt + 1'b1;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_TRAP;
    endcase
  end

  // Output logic; reset masks every enable so an interrupted access stops
  // driving memory in the reset cycle itself.
  always_comb begin
    ct_pc_wen  = 1'b0;
    ct_pc_src  = PC_SRC_SEQ;
    ct_ir_wen  = 1'b0;
    ct_iord    = 1'b0;
    ct_mem_ren = 1'b0;
    ct_mem_wen = 1'b0;
    ct_rf_wen  = 1'b0;
    ct_rf_dst  = 1'b0;
    ct_data_rf = 1'b0;
    ct_alu_src = 1'b0;
    ct_zext    = 1'b0;
    ct_alu     = ALU_ADD;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          ct_mem_ren = 1'b1;
          if (mem_ready) begin
            ct_ir_wen = 1'b1;
            ct_pc_wen = 1'b1;
          end
        end
        ST_DECODE: begin
          if (ct_inst == OP_J) begin
            ct_pc_wen = 1'b1;
            ct_pc_src = PC_SRC_JUMP;
          end
        end
        ST_EXEC: begin
          case (ct_inst)
            OP_R: ct_alu = funct_alu;
            OP_LW, OP_SW, OP_ADDIU: ct_alu_src = 1'b1;
            OP_ANDI, OP_ORI: begin
              if (EXT_EN) begin
                ct_alu_src = 1'b1;
                ct_zext    = 1'b1;
                ct_alu     = (ct_inst == OP_ANDI) ? ALU_AND : ALU_OR;
              end
            end
            OP_BEQ: begin
              ct_alu    = ALU_SUB;
              ct_pc_src = PC_SRC_BRANCH;
              ct_pc_wen = alu_zero;
            end
            OP_BNE: begin
              if (EXT_EN) begin
                ct_alu    = ALU_SUB;
                ct_pc_src = PC_SRC_BRANCH;
                ct_pc_wen = !alu_zero;
              end
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          ct_iord    = 1'b1;
          ct_mem_ren = (ct_inst == OP_LW);
          ct_mem_wen = (ct_inst == OP_SW);
        end
        ST_WB: begin
          ct_rf_wen  = 1'b1;
          ct_rf_dst  = (ct_inst == OP_R);
          ct_data_rf = (ct_inst == OP_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances: index 0 with TIMEOUT=4 and
// the extended decode on, index 1 with defaults except EXT_EN=0. Each
// instruction is expanded into its expected cycle sequence from the
// instruction's class and the memory-ready pattern.
module tb_multicycle_control;

  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                         MEM = 3'd3, WB = 3'd4, TRAP = 3'd7;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_ADDIU = 6'b001001,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam int TO_A = 4;
  localparam int TO_B = 15;

  typedef struct packed {
    logic [2:0] st;
    logic       illegal;
    logic       pc_wen;
    logic [1:0] pc_src;
    logic       ir_wen;
    logic       iord;
    logic       mem_ren;
    logic       mem_wen;
    logic       rf_wen;
    logic       rf_dst;
    logic       data_rf;
    logic       alu_src;
    logic       zext;
    logic [3:0] alu;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst = 2'b11;
  logic [1:0][5:0] inst = '0;
  logic [1:0][5:0] fn = '0;
  logic [1:0]      zero = '0;
  logic [1:0]      rdy = '0;
  logic [1:0]      pc_wen, ir_wen, iord, mem_ren, mem_wen, rf_wen, rf_dst;
  logic [1:0]      data_rf, alu_src, zext, illegal;
  logic [1:0][1:0] pc_src;
  logic [1:0][3:0] alu;
  logic [1:0][2:0] st;

  multicycle_control #(.TIMEOUT(TO_A), .EXT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst[0]), .ct_inst(inst[0]), .aluct_inst(fn[0]),
    .alu_zero(zero[0]), .mem_ready(rdy[0]),
    .ct_pc_wen(pc_wen[0]), .ct_pc_src(pc_src[0]), .ct_ir_wen(ir_wen[0]),
    .ct_iord(iord[0]), .ct_mem_ren(mem_ren[0]), .ct_mem_wen(mem_wen[0]),
    .ct_rf_wen(rf_wen[0]), .ct_rf_dst(rf_dst[0]), .ct_data_rf(data_rf[0]),
    .ct_alu_src(alu_src[0]), .ct_zext(zext[0]), .ct_alu(alu[0]),
    .ct_illegal(illegal[0]), .ct_state(st[0])
  );

  multicycle_control #(.EXT_EN(1'b0)) u_b (
    .clk(clk), .rst(rst[1]), .ct_inst(inst[1]), .aluct_inst(fn[1]),
    .alu_zero(zero[1]), .mem_ready(rdy[1]),
    .ct_pc_wen(pc_wen[1]), .ct_pc_src(pc_src[1]), .ct_ir_wen(ir_wen[1]),
    .ct_iord(iord[1]), .ct_mem_ren(mem_ren[1]), .ct_mem_wen(mem_wen[1]),
    .ct_rf_wen(rf_wen[1]), .ct_rf_dst(rf_dst[1]), .ct_data_rf(data_rf[1]),
    .ct_alu_src(alu_src[1]), .ct_zext(zext[1]), .ct_alu(alu[1]),
    .ct_illegal(illegal[1]), .ct_state(st[1])
  );

  exp_t  expv [2];
  exp_t  maskv [2];
  bit    chk_en [2] = '{1'b0, 1'b0};
  int    checks = 0;
  int    failures = 0;

  // Hand-computed literal expectations, evaluated by the compare process.
  int    lit_n = 0;
  int    lit_a [40];
  int    lit_e [40];
  string lit_name [40];
  bit    all_done = 1'b0;

  int obs_cyc [2], obs_rf [2], rf_at [2], obs_wen [2], obs_drf [2];

  logic [5:0] rf_tab [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};

  function automatic exp_t act(input int d);
    exp_t a;
    a.st = st[d];           a.illegal = illegal[d];
    a.pc_wen = pc_wen[d];   a.pc_src = pc_src[d];
    a.ir_wen = ir_wen[d];   a.iord = iord[d];
    a.mem_ren = mem_ren[d]; a.mem_wen = mem_wen[d];
    a.rf_wen = rf_wen[d];   a.rf_dst = rf_dst[d];
    a.data_rf = data_rf[d]; a.alu_src = alu_src[d];
    a.zext = zext[d];       a.alu = alu[d];
    return a;
  endfunction

  // Compare process: every checked cycle, plus the literal table at the end.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_en[d]) begin
        checks++;
        if ((act(d) & maskv[d]) !== (expv[d] & maskv[d])) begin
          failures++;
          $display("FAIL dut%0d outputs t=%0t actual=%h required=%h care=%h",
                   d, $time, act(d), expv[d], maskv[d]);
        end
      end
    end
    if (all_done) begin
      for (int k = 0; k < lit_n; k++) begin
        checks++;
        if (lit_a[k] != lit_e[k]) begin
          failures++;
          $display("FAIL %s actual=%0d required=%0d", lit_name[k], lit_a[k], lit_e[k]);
        end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic note(input string name, input int a, input int e);
    lit_name[lit_n] = name;
    lit_a[lit_n] = a;
    lit_e[lit_n] = e;
    lit_n++;
  endtask

  task automatic clr_obs(input int d);
    obs_cyc[d] = 0; obs_rf[d] = 0; rf_at[d] = 0; obs_wen[d] = 0; obs_drf[d] = 0;
  endtask

  function automatic exp_t base_e(input logic [2:0] s);
    exp_t e = '0;
    e.st = s;
    e.illegal = (s == TRAP);
    return e;
  endfunction

  // Always-relevant fields: state, trap flag and every enable/request.
  function automatic exp_t base_m();
    exp_t m = '0;
    m.st = '1; m.illegal = 1'b1; m.pc_wen = 1'b1; m.ir_wen = 1'b1;
    m.mem_ren = 1'b1; m.mem_wen = 1'b1; m.rf_wen = 1'b1;
    return m;
  endfunction

  function automatic int fn_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 2;
      6'h22, 6'h23: return 6;
      6'h24:        return 0;
      6'h25:        return 1;
      6'h2a:        return 7;
      default:      return -1;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op, input bit ext);
    case (op)
      OP_R, OP_J, OP_LW, OP_SW, OP_BEQ, OP_ADDIU: return 1'b1;
      OP_BNE, OP_ANDI, OP_ORI:                    return ext;
      default:                                    return 1'b0;
    endcase
  endfunction

  // One clock: inputs already driven; publish expectation, observe, advance.
  task automatic step(input int d, input exp_t e, input exp_t m);
    expv[d] = e;
    maskv[d] = m;
    chk_en[d] = 1'b1;
    @(negedge clk);
    obs_cyc[d]++;
    if (rf_wen[d]) begin
      obs_rf[d]++;
      rf_at[d] = obs_cyc[d];
    end
    obs_wen[d] += int'(mem_wen[d]);
    obs_drf[d] += int'(data_rf[d]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d, input logic [2:0] cur);
    exp_t e, m;
    rst[d] = 1'b1;
    inst[d] = 6'($urandom);
    rdy[d] = 1'b1;
    e = base_e(cur);
    m = base_m();
    m.alu = '1; m.iord = 1'b1;
    e.alu = A_ADD;
    step(d, e, m);
    rst[d] = 1'b0;
  endtask

  task automatic hold_trap(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      inst[d] = 6'($urandom);
      fn[d] = 6'($urandom);
      rdy[d] = 1'($urandom_range(0, 1));
      zero[d] = 1'($urandom_range(0, 1));
      step(d, base_e(TRAP), base_m());
    end
  endtask

  // fw/mw: not-ready cycles before the FETCH/MEM access completes.
  // rst_at >= 0 asserts rst in that MEM cycle (held for two cycles).
  task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] f,
                           input logic z, input int fw, input int mw,
                           input int rst_at, output int ncyc);
    exp_t e, m;
    logic [2:0] nxt;
    int k;
    int to = (d == 0) ? TO_A : TO_B;
    bit ext = (d == 0);
    ncyc = 0;
    inst[d] = op; fn[d] = f; zero[d] = z; rst[d] = 1'b0;
    for (int i = 0; i < fw; i++) begin
      rdy[d] = 1'b0;
      e = base_e(FETCH); m = base_m();
      e.mem_ren = 1'b1; m.iord = 1'b1;
      step(d, e, m);
      ncyc++;
      if (i + 1 == to) return;
    end
    rdy[d] = 1'b1;
    e = base_e(FETCH); m = base_m();
    e.mem_ren = 1'b1; e.ir_wen = 1'b1; e.pc_wen = 1'b1; e.pc_src = 2'd0; e.alu = A_ADD;
    m.iord = 1'b1; m.pc_src = '1; m.alu = '1;
    step(d, e, m);
    ncyc++;
    rdy[d] = 1'($urandom_range(0, 1));
    e = base_e(DECODE); m = base_m();
    if (op == OP_J) begin
      e.pc_wen = 1'b1; e.pc_src = 2'd2; m.pc_src = '1;
      step(d, e, m);
      ncyc++;
      return;
    end
    step(d, e, m);
    ncyc++;
    if (!legal(op, ext)) return;
    rdy[d] = 1'($urandom_range(0, 1));
    e = base_e(EXEC); m = base_m();
    nxt = WB;
    case (op)
      OP_R: begin
        m.alu_src = 1'b1; e.alu_src = 1'b0;
        k = fn_alu(f);
        if (k < 0) nxt = TRAP;
        else begin
          m.alu = '1; e.alu = 4'(k);
        end
      end
      OP_LW, OP_SW, OP_ADDIU: begin
        m.alu_src = 1'b1; m.zext = 1'b1; m.alu = '1;
        e.alu_src = 1'b1; e.zext = 1'b0; e.alu = A_ADD;
        nxt = (op == OP_ADDIU) ? WB : MEM;
      end
      OP_ANDI, OP_ORI: begin
        m.alu_src = 1'b1; m.zext = 1'b1; m.alu = '1;
        e.alu_src = 1'b1; e.zext = 1'b1;
        e.alu = (op == OP_ANDI) ? A_AND : A_OR;
      end
      OP_BEQ, OP_BNE: begin
        m.alu = '1; m.pc_src = '1;
        e.alu = A_SUB; e.pc_src = 2'd1;
        e.pc_wen = (op == OP_BEQ) ? z : ~z;
        nxt = FETCH;
      end
      default: nxt = TRAP;
    endcase
    step(d, e, m);
    ncyc++;
    if (nxt != MEM && nxt != WB) return;
    if (nxt == MEM) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == rst_at) begin
          rst[d] = 1'b1;
          e = base_e(MEM); m = base_m();
          m.alu = '1; m.iord = 1'b1; e.alu = A_ADD;
          step(d, e, m);
          e.st = FETCH;
          step(d, e, m);
          rst[d] = 1'b0;
          ncyc = -1;
          return;
        end
        rdy[d] = (i >= mw);
        e = base_e(MEM); m = base_m();
        m.iord = 1'b1; e.iord = 1'b1;
        e.mem_ren = (op == OP_LW);
        e.mem_wen = (op == OP_SW);
        step(d, e, m);
        ncyc++;
        if (rdy[d]) break;
        if (i + 1 == to) return;
      end
      if (op == OP_SW) return;
    end
    rdy[d] = 1'($urandom_range(0, 1));
    e = base_e(WB); m = base_m();
    e.rf_wen = 1'b1; m.rf_dst = 1'b1; m.data_rf = 1'b1;
    e.rf_dst = (op == OP_R);
    e.data_rf = (op == OP_LW);
    step(d, e, m);
    ncyc++;
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset(0, FETCH);

    clr_obs(0);
    run_instr(0, OP_LW, 6'h00, 1'b0, 0, 0, -1, n);
    note("lw_cpi", n, 5);
    note("lw_rf_wen_count", obs_rf[0], 1);
    note("lw_rf_wen_cycle", rf_at[0], 5);
    note("lw_data_rf_count", obs_drf[0], 1);

    run_instr(0, OP_BEQ, 6'h00, 1'b1, 0, 0, -1, n);
    note("beq_taken_cpi", n, 3);
    run_instr(0, OP_BNE, 6'h00, 1'b1, 0, 0, -1, n);
    note("bne_not_taken_cpi", n, 3);
    run_instr(0, OP_BEQ, 6'h00, 1'b0, 0, 0, -1, n);
    run_instr(0, OP_BNE, 6'h00, 1'b0, 0, 0, -1, n);

    clr_obs(0);
    run_instr(0, OP_SW, 6'h00, 1'b0, 0, 3, -1, n);
    note("sw_wait3_cpi", n, 7);
    note("sw_mem_wen_cycles", obs_wen[0], 4);

    for (int i = 0; i < 7; i++) begin
      run_instr(0, OP_R, rf_tab[i], 1'b0, 0, 0, -1, n);
      if (i == 0) note("r_cpi", n, 4);
    end
    run_instr(0, OP_ADDIU, 6'h00, 1'b0, 0, 0, -1, n);
    note("addiu_cpi", n, 4);
    run_instr(0, OP_ANDI, 6'h00, 1'b0, 0, 0, -1, n);
    note("andi_cpi", n, 4);
    run_instr(0, OP_ORI, 6'h00, 1'b0, 0, 0, -1, n);
    run_instr(0, OP_J, 6'h00, 1'b0, 0, 0, -1, n);
    note("j_cpi", n, 2);

    run_instr(0, OP_LW, 6'h00, 1'b0, 2, 2, -1, n);
    note("lw_wait2_2_cpi", n, 9);
    // TIMEOUT-1 misses then ready in the TIMEOUT-th cycle: no trap
    run_instr(0, OP_LW, 6'h00, 1'b0, 3, 3, -1, n);
    note("lw_edge_cpi", n, 11);

    run_instr(0, OP_LW, 6'h00, 1'b0, 0, 2, 2, n);
    run_instr(0, OP_SW, 6'h00, 1'b0, 3, 0, -1, n);
    note("sw_after_reset_cpi", n, 7);

    run_instr(0, OP_LW, 6'h00, 1'b0, 4, 0, -1, n);
    note("fetch_timeout_cycles", n, 4);
    hold_trap(0, 5);
    do_reset(0, TRAP);

    run_instr(0, OP_SW, 6'h00, 1'b0, 0, 20, -1, n);
    note("mem_timeout_cycles", n, 7);
    hold_trap(0, 3);
    do_reset(0, TRAP);

    run_instr(0, OP_R, 6'b000111, 1'b0, 0, 0, -1, n);
    hold_trap(0, 3);
    do_reset(0, TRAP);
    run_instr(0, 6'b111111, 6'h00, 1'b0, 0, 0, -1, n);
    hold_trap(0, 2);
    do_reset(0, TRAP);
    run_instr(0, OP_J, 6'h00, 1'b0, 0, 0, -1, n);

    rst[0] = 1'b1;
    chk_en[0] = 1'b0;

    do_reset(1, FETCH);
    clr_obs(1);
    run_instr(1, OP_ORI, 6'h00, 1'b0, 0, 0, -1, n);
    note("b_ori_trap_cycles", n, 2);
    hold_trap(1, 3);
    do_reset(1, TRAP);
    run_instr(1, OP_ANDI, 6'h00, 1'b0, 0, 0, -1, n);
    hold_trap(1, 2);
    do_reset(1, TRAP);
    run_instr(1, OP_BNE, 6'h00, 1'b0, 0, 0, -1, n);
    hold_trap(1, 2);
    do_reset(1, TRAP);
    run_instr(1, OP_R, 6'b000111, 1'b0, 0, 0, -1, n);
    hold_trap(1, 3);
    note("b_bad_funct_rf_wen", obs_rf[1], 0);
    do_reset(1, TRAP);

    run_instr(1, OP_LW, 6'h00, 1'b0, 14, 0, -1, n);
    note("b_lw_wait14_cpi", n, 19);
    run_instr(1, OP_ADDIU, 6'h00, 1'b0, 0, 0, -1, n);
    note("b_addiu_cpi", n, 4);
    run_instr(1, OP_J, 6'h00, 1'b0, 0, 0, -1, n);
    note("b_j_cpi", n, 2);
    run_instr(1, OP_SW, 6'h00, 1'b0, 15, 0, -1, n);
    hold_trap(1, 2);
    do_reset(1, TRAP);
    run_instr(1, OP_BEQ, 6'h00, 1'b1, 0, 0, -1, n);
    note("b_beq_cpi", n, 3);

    chk_en[1] = 1'b0;
    rst[1] = 1'b1;
    all_done = 1'b1;
  end

endmodule
